// File: rtl/issue_queue_mw_pkg.sv
// Shared types and sizing for the multi-lane issue queue: the decoded-instruction payload
// and the pointer-wrap helper used by both ring pointers.
package issue_queue_mw_pkg;

    typedef struct packed {
        logic [13:0] pc;
        logic        bp_taken;
        logic        is_branch;
    } PC_set;

    localparam int IQ_DEPTH        = 16;
    localparam int IQ_PUSH_W       = 2;
    localparam int IQ_POP_W        = 2;
    localparam int IQ_AFULL_MARGIN = 6;

    // One conditional subtract is enough because k never exceeds depth.
    function automatic int iq_wrap(input int ptr, input int k, input int depth);
        int s;
        s = ptr + k;
        if (s >= depth) s = s - depth;
        return s;
    endfunction

endpackage

// File: rtl/issue_queue_mw_ring_ptr.sv
// Ring pointer over an arbitrary-depth buffer: advances by 0..MAXK per cycle,
// wraps modulo DEPTH, clears to zero on clr_i.
module iq_ring_ptr
    import issue_queue_mw_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int MAXK  = 2,
    localparam int PW   = $clog2(DEPTH),
    localparam int KW   = $clog2(MAXK + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          clr_i,
    input  logic [KW-1:0] adv_i,
    output logic [PW-1:0] ptr_o
);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) ptr_d = '0;
        else       ptr_d = PW'(iq_wrap(int'(ptr_q), int'(adv_i), DEPTH));
    end

    always_ff @(posedge clk) begin
        if (!rstn) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/issue_queue_mw.sv
// Multi-lane issue queue: up to PUSH_W entries in per cycle, oldest POP_W presented to issue.
// Occupancy is tracked in count_q; pointers are never compared to decide full or empty.
module issue_queue_mw
    import issue_queue_mw_pkg::*;
#(
    parameter int DATA_W       = $bits(PC_set),
    parameter int DEPTH        = IQ_DEPTH,
    parameter int PUSH_W       = IQ_PUSH_W,
    parameter int POP_W        = IQ_POP_W,
    parameter int AFULL_MARGIN = IQ_AFULL_MARGIN
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [PUSH_W-1:0]            i_valid,
    input  logic [PUSH_W*DATA_W-1:0]     i_data,
    output logic                         o_in_ready,
    input  logic [$clog2(POP_W+1)-1:0]   i_pop_num,
    output logic [POP_W-1:0]             o_valid,
    output logic [POP_W*DATA_W-1:0]      o_data,
    input  logic                         flush,
    input  logic                         stall,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_almost_full
);

    localparam int CW  = $clog2(DEPTH + 1);
    localparam int PW  = $clog2(DEPTH);
    localparam int PNW = $clog2(PUSH_W + 1);
    localparam int PPW = $clog2(POP_W + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [CW-1:0]     count_q, count_d;
    logic              afull_q, afull_d;
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [PNW-1:0]    push_cnt, push_n;
    logic [PPW-1:0]    pop_n;
    logic              in_ready;

    // Ready looks only at registered count, never at this cycle's pop.
    assign in_ready = (CW'(DEPTH) - count_q) >= CW'(PUSH_W);

    always_comb begin
        push_cnt = '0;
        for (int i = 0; i < PUSH_W; i++) push_cnt = push_cnt + PNW'(i_valid[i]);
        push_n = (in_ready && !flush) ? push_cnt : '0;
    end

    always_comb begin
        pop_n = '0;
        if (!stall) begin
            if (CW'(i_pop_num) > count_q) pop_n = PPW'(count_q);
            else                          pop_n = i_pop_num;
        end
    end

    always_comb begin
        count_d = count_q + CW'(push_n) - CW'(pop_n);
        if (flush) count_d = '0;
        afull_d = (DEPTH - int'(count_d)) <= AFULL_MARGIN;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            count_q <= '0;
            afull_q <= (DEPTH <= AFULL_MARGIN);
        end else begin
            count_q <= count_d;
            afull_q <= afull_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < PUSH_W; i++) begin
            if (i < int'(push_n)) mem[PW'(iq_wrap(int'(wr_ptr), i, DEPTH))] <= i_data[i*DATA_W +: DATA_W];
        end
    end

    iq_ring_ptr #(.DEPTH(DEPTH), .MAXK(PUSH_W)) u_wr_ptr (
        .clk   (clk),
        .rstn  (rstn),
        .clr_i (flush),
        .adv_i (push_n),
        .ptr_o (wr_ptr)
    );

    iq_ring_ptr #(.DEPTH(DEPTH), .MAXK(POP_W)) u_rd_ptr (
        .clk   (clk),
        .rstn  (rstn),
        .clr_i (flush),
        .adv_i (pop_n),
        .ptr_o (rd_ptr)
    );

    always_comb begin
        o_valid = '0;
        o_data  = '0;
        for (int j = 0; j < POP_W; j++) begin
            if (j < int'(count_q)) begin
                o_valid[j]                 = 1'b1;
                o_data[j*DATA_W +: DATA_W] = mem[PW'(iq_wrap(int'(rd_ptr), j, DEPTH))];
            end
        end
    end

    assign o_in_ready    = in_ready;
    assign o_count       = count_q;
    assign o_almost_full = afull_q;

    // Push lanes must be a thermometer from lane 0.
    a_valid_thermo: assert property (@(posedge clk) disable iff (!rstn)
        ((i_valid & (i_valid + 1'b1)) == '0));

endmodule
